// File: rtl/vmac_pkg.sv
// Shared types and helpers for the vector multiply-add sequencer.
// Latency: none (types, constants and pure functions only).
// Backpressure: not applicable.
package vmac_pkg;

    localparam int VLEN_DEF = 128;

    // Same encodings as the MAC unit: op[0]=VX, op[1]=negate, op[2]=VMADD form
    typedef enum logic [2:0] {
        VMACC_VV  = 3'b000,
        VMACC_VX  = 3'b001,
        VNMSAC_VV = 3'b010,
        VNMSAC_VX = 3'b011,
        VMADD_VV  = 3'b100,
        VMADD_VX  = 3'b101,
        VNMSUB_VV = 3'b110,
        VNMSUB_VX = 3'b111
    } accum_op_e;

    typedef enum logic [1:0] {
        SEW_8    = 2'b00,
        SEW_16   = 2'b01,
        SEW_32   = 2'b10,
        SEW_RSVD = 2'b11
    } sew_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_READ,
        ST_LAUNCH,
        ST_WAIT,
        ST_WRITE,
        ST_FIN
    } state_e;

    // Number of registers in an LMUL group: 1, 2, 4 or 8
    function automatic logic [3:0] group_size(input logic [1:0] lmul);
        return 4'd1 << lmul;
    endfunction

endpackage

// File: rtl/vmac_sequencer_if.sv
// Bundles the issue, VRF and MAC-control signals of the sequencer.
// Latency: none (wiring only).
// Backpressure: instr_valid/instr_ready handshake on the issue side.
interface vmac_sequencer_if #(
    parameter int VLEN = vmac_pkg::VLEN_DEF
);
    // issue side
    logic             instr_valid;
    logic             instr_ready;
    logic [2:0]       op;
    logic [1:0]       sew;
    logic             signed_mode;
    logic [1:0]       lmul;
    logic [4:0]       vs1;
    logic [4:0]       vs2;
    logic [4:0]       vd;
    logic [31:0]      rs1_data;
    // VRF read
    logic             vrf_rd_en;
    logic [4:0]       vrf_rd_addr1;
    logic [4:0]       vrf_rd_addr2;
    logic [4:0]       vrf_rd_addr3;
    logic [VLEN-1:0]  vrf_rd_data1;
    logic [VLEN-1:0]  vrf_rd_data2;
    logic [VLEN-1:0]  vrf_rd_data3;
    // MAC control
    logic [VLEN-1:0]  mac_data_A;
    logic [VLEN-1:0]  mac_data_B;
    logic [VLEN-1:0]  mac_data_C;
    logic [2:0]       mac_accum_op;
    logic [1:0]       mac_sew;
    logic             mac_signed_mode;
    logic             mac_ctrl;
    logic             mac_sew_16_32;
    logic             mac_sew_32;
    logic             mac_count_0;
    logic [VLEN-1:0]  mac_result;
    logic             mac_done;
    // VRF write
    logic             vrf_wr_en;
    logic [4:0]       vrf_wr_addr;
    logic [VLEN-1:0]  vrf_wr_data;
    // status
    logic             busy;
    logic             done;
    logic             error;

    modport master (
        input  instr_valid, op, sew, signed_mode, lmul, vs1, vs2, vd, rs1_data,
        input  vrf_rd_data1, vrf_rd_data2, vrf_rd_data3, mac_result, mac_done,
        output instr_ready, vrf_rd_en, vrf_rd_addr1, vrf_rd_addr2, vrf_rd_addr3,
        output mac_data_A, mac_data_B, mac_data_C, mac_accum_op, mac_sew,
        output mac_signed_mode, mac_ctrl, mac_sew_16_32, mac_sew_32, mac_count_0,
        output vrf_wr_en, vrf_wr_addr, vrf_wr_data, busy, done, error
    );

    modport slave (
        output instr_valid, op, sew, signed_mode, lmul, vs1, vs2, vd, rs1_data,
        output vrf_rd_data1, vrf_rd_data2, vrf_rd_data3, mac_result, mac_done,
        input  instr_ready, vrf_rd_en, vrf_rd_addr1, vrf_rd_addr2, vrf_rd_addr3,
        input  mac_data_A, mac_data_B, mac_data_C, mac_accum_op, mac_sew,
        input  mac_signed_mode, mac_ctrl, mac_sew_16_32, mac_sew_32, mac_count_0,
        input  vrf_wr_en, vrf_wr_addr, vrf_wr_data, busy, done, error
    );

endinterface

// File: rtl/vmac_scalar_bcast.sv
// Replicates the low SEW bits of the scalar operand across the full vector width.
// Latency: combinational.
// Backpressure: none.
module vmac_scalar_bcast
    import vmac_pkg::*;
#(
    parameter int VLEN = VLEN_DEF
) (
    input  logic [31:0]     rs1_i,
    input  logic [1:0]      sew_i,
    output logic [VLEN-1:0] data_o
);

    // Each output bit takes the scalar bit at the same position within its lane
    always_comb begin
        data_o = '0;
        for (int i = 0; i < VLEN; i++) begin
            case (sew_i)
                SEW_8:   data_o[i] = rs1_i[i % 8];
                SEW_16:  data_o[i] = rs1_i[i % 16];
                SEW_32:  data_o[i] = rs1_i[i % 32];
                default: data_o[i] = 1'b0;
            endcase
        end
    end

endmodule

// File: rtl/vmac_sequencer.sv
// Sequences the MAC unit for one vector multiply-add over an LMUL register group.
// Latency: per beat READ+LAUNCH+WAIT(MAC latency)+WRITE; done is registered one cycle after FIN.
// Backpressure: instr_ready only in IDLE (and not in the done cycle); stalls on mac_done up to TIMEOUT_CYCLES.
module vmac_sequencer
    import vmac_pkg::*;
#(
    parameter int VLEN           = VLEN_DEF,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic               clk,
    input  logic               reset,
    vmac_sequencer_if.master   bus
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    state_e          state_q, state_d;
    logic [2:0]      beat_q, beat_d;
    logic [TW-1:0]   tmo_q, tmo_d;
    logic            err_q, err_d;

    logic [2:0]      op_q;
    logic [1:0]      sew_q;
    logic            sgn_q;
    logic [1:0]      lmul_q;
    logic [4:0]      vs1_q, vs2_q, vd_q;
    logic [31:0]     rs1_q;

    logic [VLEN-1:0] a_q, b_q, c_q, wr_data_q;
    logic [2:0]      macop_q;
    logic [1:0]      macsew_q;
    logic            macsgn_q;
    logic            cnt0_q;
    logic            done_q, error_q;

    logic            instr_ready;
    logic            accept;
    logic [3:0]      gsize;
    logic [3:0]      gsize_m1;
    logic [4:0]      gmask;
    logic [2:0]      last_beat;
    logic            cfg_bad;
    logic [VLEN-1:0] bcast_dat;

    // Holding ready low during the done cycle keeps a held instr_valid from re-accepting at done
    assign instr_ready = (state_q == ST_IDLE) && !done_q;
    assign accept      = bus.instr_valid && instr_ready;

    assign gsize     = group_size(lmul_q);
    assign gsize_m1  = gsize - 4'd1;
    assign gmask     = {1'b0, gsize_m1};
    assign last_beat = gsize_m1[2:0];
    // vs1 alignment only matters when it is actually read as a vector
    assign cfg_bad   = (sew_q == SEW_RSVD)
                    || (!op_q[0] && (|(vs1_q & gmask)))
                    || (|(vs2_q & gmask))
                    || (|(vd_q & gmask));

    vmac_scalar_bcast #(.VLEN(VLEN)) u_bcast (
        .rs1_i  (rs1_q),
        .sew_i  (sew_q),
        .data_o (bcast_dat)
    );

    // Next-state logic: walks CHECK, then READ/LAUNCH/WAIT/WRITE per beat, then FIN
    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        tmo_d   = tmo_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_CHECK;
                    beat_d  = 3'd0;
                    err_d   = 1'b0;
                end
            end
            ST_CHECK: begin
                if (cfg_bad) begin
                    err_d   = 1'b1;
                    state_d = ST_FIN;
                end else begin
                    state_d = ST_READ;
                end
            end
            ST_READ:   state_d = ST_LAUNCH;
            ST_LAUNCH: begin
                tmo_d   = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (bus.mac_done) begin
                    state_d = ST_WRITE;
                end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    err_d   = 1'b1;
                    state_d = ST_FIN;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            ST_WRITE: begin
                if (beat_q == last_beat) begin
                    state_d = ST_FIN;
                end else begin
                    beat_d  = beat_q + 3'd1;
                    state_d = ST_READ;
                end
            end
            ST_FIN:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM state, beat index, timeout counter and latched error
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            beat_q  <= 3'd0;
            tmo_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            tmo_q   <= tmo_d;
            err_q   <= err_d;
        end
    end

    // Instruction fields captured on accept and held for the whole instruction
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_q   <= '0;
            sew_q  <= '0;
            sgn_q  <= 1'b0;
            lmul_q <= '0;
            vs1_q  <= '0;
            vs2_q  <= '0;
            vd_q   <= '0;
            rs1_q  <= '0;
        end else if (accept) begin
            op_q   <= bus.op;
            sew_q  <= bus.sew;
            sgn_q  <= bus.signed_mode;
            lmul_q <= bus.lmul;
            vs1_q  <= bus.vs1;
            vs2_q  <= bus.vs2;
            vd_q   <= bus.vd;
            rs1_q  <= bus.rs1_data;
        end
    end

    // MAC operands/config registered in LAUNCH so they are stable for the whole WAIT; result captured on mac_done
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a_q       <= '0;
            b_q       <= '0;
            c_q       <= '0;
            macop_q   <= '0;
            macsew_q  <= '0;
            macsgn_q  <= 1'b0;
            cnt0_q    <= 1'b0;
            wr_data_q <= '0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            cnt0_q  <= (state_q == ST_LAUNCH);
            done_q  <= (state_q == ST_FIN);
            error_q <= (state_q == ST_FIN) && err_q;
            if (state_q == ST_LAUNCH) begin
                a_q      <= op_q[0] ? bcast_dat : bus.vrf_rd_data1;
                b_q      <= bus.vrf_rd_data2;
                c_q      <= bus.vrf_rd_data3;
                macop_q  <= op_q;
                macsew_q <= sew_q;
                macsgn_q <= sgn_q;
            end
            if ((state_q == ST_WAIT) && bus.mac_done) begin
                wr_data_q <= bus.mac_result;
            end
        end
    end

    assign bus.instr_ready     = instr_ready;
    assign bus.vrf_rd_en       = (state_q == ST_READ);
    assign bus.vrf_rd_addr1    = vs1_q + {2'b00, beat_q};
    assign bus.vrf_rd_addr2    = vs2_q + {2'b00, beat_q};
    assign bus.vrf_rd_addr3    = vd_q + {2'b00, beat_q};
    assign bus.mac_data_A      = a_q;
    assign bus.mac_data_B      = b_q;
    assign bus.mac_data_C      = c_q;
    assign bus.mac_accum_op    = macop_q;
    assign bus.mac_sew         = macsew_q;
    assign bus.mac_signed_mode = macsgn_q;
    assign bus.mac_ctrl        = macop_q[1];
    assign bus.mac_sew_16_32   = (macsew_q != SEW_8);
    assign bus.mac_sew_32      = (macsew_q == SEW_32);
    assign bus.mac_count_0     = cnt0_q;
    assign bus.vrf_wr_en       = (state_q == ST_WRITE);
    assign bus.vrf_wr_addr     = vd_q + {2'b00, beat_q};
    assign bus.vrf_wr_data     = wr_data_q;
    assign bus.busy            = (state_q != ST_IDLE);
    assign bus.done            = done_q;
    assign bus.error           = error_q;

    // sgn_q only reaches the MAC through macsgn_q; keep the pairing explicit for readers
    logic unused_ok;
    assign unused_ok = sgn_q ^ macsgn_q;

endmodule

// File: doc/vmac_sequencer.md
Name: vmac_sequencer

Overview:
- Controller that sequences `vector_multiply_add_unit` for one vector multiply-add instruction (VMACC/VNMSAC/VMADD/VNMSUB, .vv/.vx) across an LMUL register group.
- Per group register ("beat"): reads operands from the VRF, broadcasts the scalar for .vx, configures and starts the MAC unit, waits for completion, then writes the result back to vd.
- Sits between the vector issue stage and the MAC datapath; owns all MAC control inputs.

Parameters:
- VLEN, `MAX_VLEN: vector register and datapath width in bits.
- TIMEOUT_CYCLES, 64: maximum WAIT cycles per beat before abort.

Ports:
- clk  input  1  clock
- reset  input  1  reset
- instr_valid  input  1  instruction offered
- instr_ready  output  1  sequencer can accept; high only in IDLE
- op  input  3  accum_op encoding: 000 VMACC_VV … 111 VNMSUB_VX; op[0]=VX, op[1]=negate, op[2]=VMADD form
- sew  input  2  00=8, 01=16, 10=32 bits; 11 illegal
- signed_mode  input  1  signed multiply
- lmul  input  2  group size 1/2/4/8 for codes 00/01/10/11
- vs1, vs2, vd  input  5 each  register indices
- rs1_data  input  32  scalar operand for .vx
- vrf_rd_en  output  1  VRF read strobe
- vrf_rd_addr1/2/3  output  5 each  vs1+beat, vs2+beat, vd+beat
- vrf_rd_data1/2/3  input  VLEN each  read data, valid the cycle after vrf_rd_en
- mac_data_A/B/C  output  VLEN each  registered MAC operands
- mac_accum_op  output  3  registered op
- mac_sew  output  2; mac_signed_mode  output  1
- mac_ctrl  output  1  equals op[1]
- mac_sew_16_32  output  1  sew != 00
- mac_sew_32  output  1  sew == 10
- mac_count_0  output  1  one-cycle MAC start pulse
- mac_result  input  VLEN  sum_product_result
- mac_done  input  1  product_sum_done
- vrf_wr_en  output  1; vrf_wr_addr  output  5; vrf_wr_data  output  VLEN
- busy  output  1  state != IDLE
- done  output  1  one-cycle pulse at instruction end
- error  output  1  valid with done; indicates illegal config or timeout

Behaviour:
- Reset is asynchronous, active-low (reset=0). It forces IDLE, clears beat and timeout counters, and drives every output to 0 except instr_ready=1. Reset mid-operation aborts the instruction with no further VRF write.
- Accept: instr_valid && instr_ready latches all instruction fields, sets beat=0, enters CHECK.
- CHECK (1 cycle): error if sew==11, or if any of vs1 (VV only), vs2 or vd is not a multiple of the group size (1<<lmul). On error go to FIN with error=1; otherwise go to READ.
- READ (1 cycle): vrf_rd_en=1; addresses are base+beat. Go to LAUNCH.
- LAUNCH (1 cycle): register the operands.
  - mac_data_A = vrf_rd_data1 for VV. For VX, mac_data_A = rs1_data[SEW-1:0] replicated across VLEN.
  - mac_data_B = vrf_rd_data2; mac_data_C = vrf_rd_data3.
  - Pulse mac_count_0=1. Clear the timeout counter. Go to WAIT.
- WAIT: hold all mac_* outputs stable.
  - On mac_done, capture mac_result into vrf_wr_data and go to WRITE.
  - If the counter reaches TIMEOUT_CYCLES without mac_done, go to FIN with error=1 and no write.
  - A mac_done in the LAUNCH cycle is ignored.
- WRITE (1 cycle): vrf_wr_en=1, vrf_wr_addr=vd+beat.
  - If beat == (1<<lmul)-1, go to FIN.
  - Otherwise beat++ and go to READ.
- FIN (1 cycle): done=1 and error as latched. Return to IDLE.
- Minimum latency per beat: 3 cycles + MAC latency + 1. Instruction start to done: 2 + beats×(per-beat latency).
- Register indices are 5-bit; alignment checking guarantees base+beat never wraps past 31.
- Write and done never coincide. instr_valid is ignored while busy.

Decomposition:
- Shared package vmac_pkg:
  - accum_op_e enum (same encodings as the MAC unit)
  - sew_e
  - lmul-to-group-size function
  - state enum {IDLE, CHECK, READ, LAUNCH, WAIT, WRITE, FIN}
- Sub-module vmac_scalar_bcast: combinational replicate of rs1 by sew.
- FSM and counters stay in the top module.

Test Plan:
- VMACC_VV, sew=00, lmul=00, vs1=1, vs2=2, vd=3; v1 bytes=3, v2 bytes=4, v3 bytes=5; MAC model returns 17 per byte after 4 cycles.
  - Expect one count_0 pulse and ctrl=0.
  - Expect one write to v3 with all bytes 0x11, then done with error=0.
- VNMSUB_VX, sew=10, rs1_data=0x0000_0002, lmul=01, vd=4.
  - Expect mac_data_A = every 32-bit lane 2, ctrl=1, sew_16_32=1, sew_32=1.
  - Expect writes to v4 then v5 in order, with two count_0 pulses.
- sew=11, or lmul=10 with vd=6: expect no vrf_rd_en and no write; done=1 with error=1 three cycles after accept.
- MAC model never asserts mac_done: expect error=1 and done after TIMEOUT_CYCLES WAIT cycles, with no vrf_wr_en.
- Assert reset=0 during WAIT of beat 1 of an lmul=11 instruction.
  - Expect immediate IDLE, instr_ready=1, no further writes.
  - A new instruction after reset release completes normally.
- Hold instr_valid high during a busy instruction: expect instr_ready=0 and no second accept until after done.
